// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types, constants and helpers for the multi-channel
//               clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int DIV_WIDTH      = 16;
  localparam int MIN_ACTIVE_DIV = 2;

  typedef logic [DIV_WIDTH-1:0] div_t;

  // First counter value of the high phase; odd divisors give the extra cycle to high.
  function automatic logic [31:0] hi_start(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_channel.sv
// ============================================================================
// Module      : clk_div_channel
// Description : One divider channel: period counter, pending divisor and
//               registered square-wave / wrap-tick outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_div,
  output logic             o_clk_out,
  output logic             o_tick
);

  localparam logic [WIDTH-1:0] C_DEFAULT = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_MIN     = WIDTH'(MIN_ACTIVE_DIV);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_d_act;
  logic [WIDTH-1:0] r_d_pend;
  logic             r_pend_vld;
  logic             r_clk_out;
  logic             r_tick;

  logic             w_active;
  logic             w_wrap;
  logic             w_apply;
  logic             w_active_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_d_act_nxt;
  logic [WIDTH-1:0] w_d_pend_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic             w_pend_vld_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;

  always_comb begin
    w_active = (r_d_act >= C_MIN);
    w_wrap   = w_active && i_en && (r_cnt == (r_d_act - C_ONE));
    // A disabled channel has no period boundary, so its pending value goes in at once.
    w_apply  = i_sync || w_wrap || (!w_active && r_pend_vld);

    w_d_act_nxt = w_apply ? r_d_pend : r_d_act;

    if (w_apply || !w_active) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + C_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    // A write landing on a wrap cycle stays pending for the following boundary.
    w_d_pend_nxt   = i_wr ? i_wr_div : r_d_pend;
    w_pend_vld_nxt = i_wr ? 1'b1 : (w_apply ? 1'b0 : r_pend_vld);

    w_active_nxt = (w_d_act_nxt >= C_MIN);
    w_hi_nxt     = WIDTH'(hi_start(32'(w_d_act_nxt)));
    w_clk_nxt    = w_active_nxt && (w_cnt_nxt >= w_hi_nxt);
    w_tick_nxt   = w_active_nxt && i_en && !i_sync &&
                   (w_cnt_nxt == (w_d_act_nxt - C_ONE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_d_act    <= C_DEFAULT;
      r_d_pend   <= C_DEFAULT;
      r_pend_vld <= 1'b0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_d_act    <= w_d_act_nxt;
      r_d_pend   <= w_d_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_clk_out  <= w_clk_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module      : clk_div_multi
// Description : N_CH independent programmable clock-enable dividers with
//               glitch-free divisor updates at period boundaries.
//               Optional macro CLK_DIV_SYNC_EN adds the `sync` phase-align input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int WIDTH       = 16,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic w_sync;
  logic w_wr_ok;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Out-of-range channel numbers are dropped rather than aliased.
  assign w_wr_ok = wr_en && (int'(wr_ch) < N_CH);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic w_wr;

    assign w_wr = w_wr_ok && (int'(wr_ch) == c);

    clk_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_en      (en),
      .i_sync    (w_sync),
      .i_wr      (w_wr),
      .i_wr_div  (wr_div),
      .o_clk_out (clk_out[c]),
      .o_tick    (tick[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi: vector table, directed
//               corner sequences and random traffic against a period model.
//               Exercises `sync` when CLK_DIV_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         en      = 1'b0;
  logic         wr_en   = 1'b0;
  logic         sync    = 1'b0;
  logic [1:0]   wr_ch   = '0;
  logic [W-1:0] wr_div  = '0;
  logic [N-1:0] clk_out;
  logic [N-1:0] tick;

  always #5 clk = ~clk;

  clk_div_multi #(
    .N_CH        (N),
    .WIDTH       (W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CLK_DIV_SYNC_EN
    .sync    (sync),
`endif
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // Reference: per channel, position inside the current period and divisors.
  int           m_pos [N];
  int           m_d   [N];
  int           m_dp  [N];
  bit           m_pv  [N];
  logic [N-1:0] m_clk;
  logic [N-1:0] m_tick;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         en;
    bit         wr;
    logic [1:0] ch;
    logic [15:0] div;
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
  } vec_t;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_pos[c] = 0;
      m_d[c]   = 2;
      m_dp[c]  = 2;
      m_pv[c]  = 1'b0;
    end
    m_clk  = '0;
    m_tick = '0;
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < N; c++) begin
      bit running;
      bit boundary;
      running = (m_d[c] >= 2);
      if (sync)         boundary = 1'b1;
      else if (running) boundary = en && (m_pos[c] == m_d[c] - 1);
      else              boundary = m_pv[c];
      if (boundary) begin
        m_d[c]   = m_dp[c];
        m_pos[c] = 0;
        m_pv[c]  = 1'b0;
      end else if (running && en) begin
        m_pos[c] = m_pos[c] + 1;
      end
      if (wr_en && int'(wr_ch) == c) begin
        m_dp[c] = int'(wr_div);
        m_pv[c] = 1'b1;
      end
      m_clk[c]  = (m_d[c] >= 2) && (m_pos[c] >= m_d[c] / 2);
      m_tick[c] = (m_d[c] >= 2) && en && !sync && (m_pos[c] == m_d[c] - 1);
    end
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    expect_eq({tag, "_clk_out"}, 32'(clk_out), 32'(m_clk));
    expect_eq({tag, "_tick"},    32'(tick),    32'(m_tick));
  endtask

  initial begin
    vec_t        tbl [10];
    logic [13:0] seq14_c, seq14_t;
    logic [11:0] seq12;
    logic [3:0]  seq4_c, seq4_t;
    logic [2:0]  seq3_c, seq3_t;
    int          k;

    // D=2 everywhere after reset; ch1 reprogrammed to 5, then a one-cycle freeze.
    tbl[0] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 16'd5, 4'h0, 4'h0};
    tbl[2] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF};
    tbl[3] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hD, 4'hD};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'hD, 4'h0};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0};
    tbl[7] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hF, 4'hD};
    tbl[8] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2};
    tbl[9] = '{1'b1, 1'b0, 2'd0, 16'd0, 4'hD, 4'hD};

    model_reset();
    #2;
    expect_eq("reset_clk_out", 32'(clk_out), 32'h0);
    expect_eq("reset_tick",    32'(tick),    32'h0);
    #5 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      en     = tbl[i].en;
      wr_en  = tbl[i].wr;
      wr_ch  = tbl[i].ch;
      wr_div = tbl[i].div;
      step("tbl");
      expect_eq($sformatf("tbl%0d_clk", i),  32'(clk_out), 32'(tbl[i].exp_clk));
      expect_eq($sformatf("tbl%0d_tick", i), 32'(tick),    32'(tbl[i].exp_tick));
    end
    wr_en = 1'b0;
    en    = 1'b1;

    // ch2 at D=4, rewritten to 6 at cnt=1: current period completes, then 3 low / 3 high.
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd4;
    step("wr2");
    wr_en = 1'b0;
    k = 0;
    while (!(m_d[2] == 4 && m_pos[2] == 1) && k < 20) begin
      step("seq_a_wait");
      k++;
    end
    expect_eq("ch2_reach_cnt1", 32'(k < 20), 32'h1);
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd6;
    seq14_c = '0; seq14_t = '0;
    for (int i = 0; i < 14; i++) begin
      step("seq_a");
      wr_en = 1'b0;
      seq14_c = {seq14_c[12:0], clk_out[2]};
      seq14_t = {seq14_t[12:0], tick[2]};
    end
    expect_eq("ch2_d4_to_d6_clk",  32'(seq14_c), 32'(14'b11000111000111));
    expect_eq("ch2_d4_to_d6_tick", 32'(seq14_t), 32'(14'b01000001000001));

    // ch3 disabled with D=0, then restarted with D=3.
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd0;
    step("seq_b_off");
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) step("seq_b_drain");
    seq3_c = '1; seq3_t = '1;
    for (int i = 0; i < 3; i++) begin
      step("seq_b_idle");
      seq3_c = {seq3_c[1:0], clk_out[3]};
      seq3_t = {seq3_t[1:0], tick[3]};
    end
    expect_eq("ch3_disabled_clk",  32'(seq3_c), 32'h0);
    expect_eq("ch3_disabled_tick", 32'(seq3_t), 32'h0);
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd3;
    seq4_c = '0; seq4_t = '0;
    for (int i = 0; i < 4; i++) begin
      step("seq_b_on");
      wr_en = 1'b0;
      seq4_c = {seq4_c[2:0], clk_out[3]};
      seq4_t = {seq4_t[2:0], tick[3]};
    end
    expect_eq("ch3_restart_clk",  32'(seq4_c), 32'(4'b0011));
    expect_eq("ch3_restart_tick", 32'(seq4_t), 32'(4'b0001));

    // Freeze for 7 cycles with ch1 (D=5) at cnt=2, then resume at the same point.
    k = 0;
    while (m_pos[1] != 2 && k < 20) begin
      step("seq_c_wait");
      k++;
    end
    expect_eq("ch1_reach_cnt2", 32'(k < 20), 32'h1);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step("seq_c_frozen");
      expect_eq($sformatf("frozen%0d_tick", i), 32'(tick), 32'h0);
    end
    en = 1'b1;
    seq3_c = '0; seq3_t = '0;
    for (int i = 0; i < 3; i++) begin
      step("seq_c_resume");
      seq3_c = {seq3_c[1:0], clk_out[1]};
      seq3_t = {seq3_t[1:0], tick[1]};
    end
    expect_eq("ch1_resume_clk",  32'(seq3_c), 32'(3'b110));
    expect_eq("ch1_resume_tick", 32'(seq3_t), 32'(3'b010));

    // Asynchronous reset mid-period discards a pending write to ch0.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd7;
    step("seq_d_wr");
    wr_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    expect_eq("async_reset_clk_out", 32'(clk_out), 32'h0);
    expect_eq("async_reset_tick",    32'(tick),    32'h0);
    model_reset();
    #1 reset_n = 1'b1;
    seq4_c = '0;
    for (int i = 0; i < 4; i++) begin
      step("seq_d_post");
      seq4_c = {seq4_c[2:0], clk_out[0]};
    end
    expect_eq("ch0_after_reset_clk", 32'(seq4_c), 32'(4'b1010));
    for (int i = 0; i < 12; i++) step("seq_d_run");

`ifdef CLK_DIV_SYNC_EN
    // ch2 at D=3 and ch3 at D=4 with unrelated phases, then aligned by sync.
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd3;
    step("seq_e_wr2");
    wr_ch = 2'd3; wr_div = 16'd4;
    step("seq_e_wr3");
    wr_en = 1'b0;
    for (int i = 0; i < 9; i++) step("seq_e_run");
    sync = 1'b1;
    step("seq_e_sync");
    sync = 1'b0;
    expect_eq("sync_clk_out", 32'(clk_out), 32'h0);
    expect_eq("sync_tick",    32'(tick),    32'h0);
    seq12 = '0;
    for (int i = 0; i < 12; i++) begin
      step("seq_e_align");
      seq12 = {seq12[10:0], tick[2] & tick[3]};
    end
    expect_eq("sync_tick_coincide", 32'(seq12), 32'(12'b000000000010));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_div = ($urandom_range(0, 199) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9));
`ifdef CLK_DIV_SYNC_EN
      sync   = ($urandom_range(0, 29) == 0);
`endif
      step("rand");
    end
    wr_en = 1'b0;
    sync  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised, multi-channel successor to the single-channel frequency divider. It derives N_CH independent divided clock-enable waveforms from the one system clock. Each channel has a runtime-programmable divisor that is applied glitch-free at the channel's next period boundary. Outputs are synchronous square waves plus one-cycle wrap ticks that feed slower logic on the DE1-SoC (LED scanners, tone generators, sample strobes).

## Interface
- N_CH, 4: number of channels (1..16)
- WIDTH, 16: divisor and counter width in bits
- DEFAULT_DIV, 2: divisor loaded into every channel at reset
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global run enable; 0 freezes all counters and outputs
- wr_en  in  1  divisor write strobe, one cycle per write
- wr_ch  in  $clog2(N_CH) (min 1)  target channel of the write
- wr_div  in  WIDTH  new divisor value D
- clk_out  out  N_CH  divided square wave per channel, registered
- tick  out  N_CH  one-cycle pulse on the last cycle of each period, registered
- sync  in  1  present only with CLK_DIV_SYNC_EN (see Configuration)

## Operation
- Per channel state: cnt (WIDTH), d_act (active divisor), d_pend (pending divisor), pend_vld.
- Reset (asynchronous, reset_n=0): cnt=0, d_act=d_pend=DEFAULT_DIV, pend_vld=0, clk_out=0, tick=0. Reset mid-period discards pending writes.
- Active channel (d_act >= 2), en=1: cnt counts 0..d_act-1, then wraps to 0.
- Waveform invariant (every cycle, active channel): clk_out[c] == (cnt >= d_act/2) (integer floor). clk_out is low for floor(D/2) cycles and high for ceil(D/2) cycles. Period is D input cycles. Odd D gives the extra cycle to the high phase.
- tick[c] == (cnt == d_act-1).
- Disabled channel (d_act = 0 or 1): cnt held 0, clk_out=0, tick=0.
- Write: when wr_en=1 and wr_ch < N_CH, set d_pend[wr_ch]=wr_div and pend_vld=1. When wr_ch >= N_CH, the write is ignored. If a channel is written twice before its pending value is applied, the last write wins.
- Apply pending: at a wrap (cnt == d_act-1 with en=1), set d_act=d_pend, cnt=0, pend_vld=0. If the channel is disabled, the pending value is applied on the next cycle regardless of en.
- A write and a wrap on the same channel in the same cycle: the wrap applies the previous d_pend. The new value is held pending until the following wrap.
- en=0: cnt, clk_out and tick are held. tick is forced to 0 while en=0. Writes are still accepted.

## Timing
- Registered outputs; there are no combinational paths from inputs to outputs.
- Write to effect: a written divisor governs the cycle after the next wrap. For a disabled channel, it takes effect 2 cycles after wr_en.
- The first period after reset, or after enabling a channel, starts with the low phase.
- en deasserted then reasserted: the waveform resumes exactly where it froze. No phase is lost.
- Counter comparisons are WIDTH-bit unsigned. D = 2^WIDTH-1 is legal.

## Configuration
- CLK_DIV_SYNC_EN defined: the `sync` input exists. sync=1 forces, for all channels in the next cycle: cnt=0, pending divisors applied, clk_out=0, tick=0. sync takes priority over en and over a same-cycle wrap. This phase-aligns all channels.
- CLK_DIV_SYNC_EN not defined: the port and its logic are absent. Channel phases depend only on reset and write history.

## Structure
- Package clk_div_pkg holds:
  - typedef div_t (logic [WIDTH-1:0]) with default width 16
  - constant MIN_ACTIVE_DIV = 2
  - function hi_start(D) returning D/2
- Sub-module clk_div_channel implements one channel: counter, pending register, output flops. It takes the write strobe already decoded for that channel.
- The top level decodes wr_ch, fans out en/sync and generates N_CH instances.

## Test plan
- Reset, DEFAULT_DIV=2, en=1 -> clk_out[0] alternates 0,1,0,1. tick is high on every cycle in which clk_out=1.
- Write ch1 D=5, then wait for apply -> clk_out[1] pattern 0,0,1,1,1 repeating. tick high on the 5th cycle only.
- ch2 running D=4, write D=6 at cnt=1 -> ch2 completes the current 4-cycle period, then runs 3 low / 3 high. There is no short or glitched period.
- Write ch3 D=0 -> within 1 period, clk_out[3]=0 and tick[3]=0 held. Then write D=3 -> pattern starts 2 cycles later as 0,1,1.
- en=0 for 7 cycles mid-period, then en=1 -> outputs frozen with tick=0, then resume at the same cnt. Assert reset_n=0 mid-period -> all outputs 0 immediately, and the pending write is lost.
- With CLK_DIV_SYNC_EN: channels at D=3 and D=4 with different phases, pulse sync -> next cycle both at cnt=0, clk_out=0. Their ticks coincide every 12 cycles.
